vga_sync_gen: RTL and testbench

Consumes the divided pixel clock `clk_25MHz` produced by the clock divider and generates 640x480@60 VGA timing. The block does not clock logic on the divided clock. It runs entirely on `device_clock` (100 MHz) and edge-detects `clk_25MHz` to form a one-cycle pixel strobe. Outputs (`hsync`, `vsync`, `video_on`, pixel coordinates, frame/line markers) feed the renderer and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/rise_detect.sv | 24 ++
 rtl/vga_sync_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 640x480@60 constants.
// Phase literals carry an HP_/VP_ prefix so they never collide with timing parameter names.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int CNT_RANGE = 1 << CNT_W;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef enum logic [1:0] {
    HP_ACTIVE = 2'd0,
    HP_FRONT  = 2'd1,
    HP_SYNC   = 2'd2,
    HP_BACK   = 2'd3
  } h_phase_t;

  typedef enum logic [1:0] {
    VP_ACTIVE = 2'd0,
    VP_FRONT  = 2'd1,
    VP_SYNC   = 2'd2,
    VP_BACK   = 2'd3
  } v_phase_t;

  function automatic int timing_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector for a level already synchronous to device_clock.
// RESET_LEVEL is the assumed prior level, so a signal that idles at that level yields no edge after reset.
module rise_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic device_clock,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_d;

  always_ff @(posedge device_clock or posedge rst) begin
    if (rst) begin
      r_level_d <= RESET_LEVEL;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator running on device_clock, stepping once per rising edge of clk_25MHz.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             device_clock,
  input  logic             rst,
  input  logic             clk_25MHz,
  output logic             pix_stb,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > CNT_RANGE) begin : g_h_total_err
      $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > CNT_RANGE) begin : g_v_total_err
      $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end
  endgenerate

  // Last count of each phase; the phase FSMs leave a phase on the tick at these counts.
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_VISIBLE + H_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_VISIBLE + V_FP - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_v_step;
  logic             w_frame_hit;
  logic [CNT_W-1:0] w_hcnt_next;
  logic [CNT_W-1:0] w_vcnt_next;
  h_phase_t         w_hph_next;
  v_phase_t         w_vph_next;

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  h_phase_t         r_hph;
  v_phase_t         r_vph;
  logic             r_pix_stb;
  logic             r_video_on;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_line_start;
  logic             r_frame_start;

  rise_detect #(
    .RESET_LEVEL (1'b1)
  ) u_pix_edge (
    .device_clock (device_clock),
    .rst          (rst),
    .i_level      (clk_25MHz),
    .o_rise       (w_tick)
  );

  always_comb begin
    w_h_wrap    = (r_hcnt == H_LAST);
    w_v_wrap    = (r_vcnt == V_LAST);
    w_v_step    = w_tick & w_h_wrap;
    w_hcnt_next = r_hcnt;
    w_vcnt_next = r_vcnt;
    if (w_tick) begin
      w_hcnt_next = w_h_wrap ? '0 : r_hcnt + 1'b1;
    end
    if (w_v_step) begin
      w_vcnt_next = w_v_wrap ? '0 : r_vcnt + 1'b1;
    end
    w_frame_hit = w_tick && (w_hcnt_next == '0) && (w_vcnt_next == '0);
  end

  always_comb begin
    w_hph_next = r_hph;
    if (w_tick) begin
      case (r_hph)
        HP_ACTIVE: if (r_hcnt == H_ACT_END)  w_hph_next = HP_FRONT;
        HP_FRONT:  if (r_hcnt == H_FP_END)   w_hph_next = HP_SYNC;
        HP_SYNC:   if (r_hcnt == H_SYNC_END) w_hph_next = HP_BACK;
        HP_BACK:   if (r_hcnt == H_LAST)     w_hph_next = HP_ACTIVE;
        default:   w_hph_next = HP_BACK;
      endcase
    end
  end

  // Vertical phase uses the same boundaries on vcnt but only moves at end of line.
  always_comb begin
    w_vph_next = r_vph;
    if (w_v_step) begin
      case (r_vph)
        VP_ACTIVE: if (r_vcnt == V_ACT_END)  w_vph_next = VP_FRONT;
        VP_FRONT:  if (r_vcnt == V_FP_END)   w_vph_next = VP_SYNC;
        VP_SYNC:   if (r_vcnt == V_SYNC_END) w_vph_next = VP_BACK;
        VP_BACK:   if (r_vcnt == V_LAST)     w_vph_next = VP_ACTIVE;
        default:   w_vph_next = VP_BACK;
      endcase
    end
  end

  always_ff @(posedge device_clock or posedge rst) begin
    if (rst) begin
      r_hcnt <= H_LAST;
      r_vcnt <= V_LAST;
      r_hph  <= HP_BACK;
      r_vph  <= VP_BACK;
    end else begin
      r_hcnt <= w_hcnt_next;
      r_vcnt <= w_vcnt_next;
      r_hph  <= w_hph_next;
      r_vph  <= w_vph_next;
    end
  end

  // Outputs are built from next-state values so they line up with pix_stb.
  always_ff @(posedge device_clock or posedge rst) begin
    if (rst) begin
      r_pix_stb     <= 1'b0;
      r_video_on    <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_stb     <= w_tick;
      r_video_on    <= (w_hph_next == HP_ACTIVE) && (w_vph_next == VP_ACTIVE);
      r_hsync       <= (w_hph_next == HP_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      r_vsync       <= (w_vph_next == VP_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      r_line_start  <= w_tick && (w_hcnt_next == '0);
      r_frame_start <= w_frame_hit;
    end
  end

  assign pix_stb     = r_pix_stb;
  assign pixel_x     = r_hcnt;
  assign pixel_y     = r_vcnt;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge device_clock or posedge rst) begin
    if (rst) begin
      r_frame_count <= '0;
    end else if (w_frame_hit) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: a full-size instance and a small active-high-sync instance
// are checked every cycle against a tick-count reference model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       stb;
    logic [9:0] x;
    logic [9:0] y;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vga_obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c25 = 1'b1;

  always #5 clk = ~clk;

  logic       d_stb, d_vid, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_stb, s_vid, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
  logic [15:0] fc_exp = 16'd0;
`endif

  vga_sync_gen u_dut (
    .device_clock (clk),
    .rst          (rst),
    .clk_25MHz    (c25),
    .pix_stb      (d_stb),
    .pixel_x      (d_x),
    .pixel_y      (d_y),
    .video_on     (d_vid),
    .hsync        (d_hs),
    .vsync        (d_vs),
    .line_start   (d_ls),
    .frame_start  (d_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count  (d_fc)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE       (16),
    .H_FP            (2),
    .H_SYNC          (4),
    .H_BP            (3),
    .V_VISIBLE       (6),
    .V_FP            (1),
    .V_SYNC          (2),
    .V_BP            (2),
    .SYNC_ACTIVE_LOW (1'b0)
  ) u_dut_s (
    .device_clock (clk),
    .rst          (rst),
    .clk_25MHz    (c25),
    .pix_stb      (s_stb),
    .pixel_x      (s_x),
    .pixel_y      (s_y),
    .video_on     (s_vid),
    .hsync        (s_hs),
    .vsync        (s_vs),
    .line_start   (s_ls),
    .frame_start  (s_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count  (s_fc)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Position after k pixel ticks since reset: tick 1 lands on (0,0), then raster order.
  function automatic vga_obs_t model_obs(input longint k, input bit stb,
                                         input int hv, input int hfp, input int hsw, input int hbp,
                                         input int vv, input int vfp, input int vsw, input int vbp,
                                         input bit act_low);
    vga_obs_t r;
    int ht, vt, x, y;
    longint p;
    bit in_h, in_v;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (k == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      p = (k - 1) % (longint'(ht) * vt);
      x = int'(p % ht);
      y = int'(p / ht);
    end
    in_h  = (x >= hv + hfp) && (x < hv + hfp + hsw);
    in_v  = (y >= vv + vfp) && (y < vv + vfp + vsw);
    r.stb = stb;
    r.x   = 10'(x);
    r.y   = 10'(y);
    r.vid = (x < hv) && (y < vv);
    r.hs  = act_low ? !in_h : in_h;
    r.vs  = act_low ? !in_v : in_v;
    r.ls  = stb && (x == 0);
    r.fs  = stb && (x == 0) && (y == 0);
    return r;
  endfunction

  task automatic check_inst(input string nm, input vga_obs_t got, input vga_obs_t exp);
    check_eq({nm, ".pix_stb"},     32'(got.stb), 32'(exp.stb));
    check_eq({nm, ".pixel_x"},     32'(got.x),   32'(exp.x));
    check_eq({nm, ".pixel_y"},     32'(got.y),   32'(exp.y));
    check_eq({nm, ".video_on"},    32'(got.vid), 32'(exp.vid));
    check_eq({nm, ".hsync"},       32'(got.hs),  32'(exp.hs));
    check_eq({nm, ".vsync"},       32'(got.vs),  32'(exp.vs));
    check_eq({nm, ".line_start"},  32'(got.ls),  32'(exp.ls));
    check_eq({nm, ".frame_start"}, 32'(got.fs),  32'(exp.fs));
  endtask

  function automatic vga_obs_t exp_big(input longint k, input bit stb);
    return model_obs(k, stb, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
  endfunction

  function automatic vga_obs_t exp_small(input longint k, input bit stb);
    return model_obs(k, stb, 16, 2, 4, 3, 6, 1, 2, 2, 1'b0);
  endfunction

  longint   k_ticks = 0;
  bit       m_prev  = 1'b1;
  bit       m_stb   = 1'b0;
  vga_obs_t e_big, e_small;

  always @(posedge clk) begin
    if (rst) begin
      k_ticks = 0;
      m_prev  = 1'b1;
      m_stb   = 1'b0;
    end else begin
      m_stb  = c25 && !m_prev;
      m_prev = c25;
      if (m_stb) k_ticks++;
    end
    #1;
    e_big   = exp_big(k_ticks, m_stb);
    e_small = exp_small(k_ticks, m_stb);
    check_inst("big",   {d_stb, d_x, d_y, d_vid, d_hs, d_vs, d_ls, d_fs}, e_big);
    check_inst("small", {s_stb, s_x, s_y, s_vid, s_hs, s_vs, s_ls, s_fs}, e_small);
`ifdef VGA_FRAME_CNT_EN
    if (rst) fc_exp = 16'd0;
    else if (e_big.fs) fc_exp = fc_exp + 16'd1;
    check_eq("big.frame_count", 32'(d_fc), 32'(fc_exp));
`endif
  end

  int div_phase = 0;

  task automatic run_div(input int n);
    repeat (n) begin
      @(negedge clk);
      div_phase++;
      if (div_phase == 2) begin
        div_phase = 0;
        c25 = ~c25;
      end
    end
  endtask

  task automatic hold_level(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int len);
    @(negedge clk);
    rst = 1'b1;
    c25 = 1'b1;
    div_phase = 0;
    #1;
    // Asynchronous reset must show reset values before the next clock edge.
    check_inst("big_rst",   {d_stb, d_x, d_y, d_vid, d_hs, d_vs, d_ls, d_fs}, exp_big(0, 1'b0));
    check_inst("small_rst", {s_stb, s_x, s_y, s_vid, s_hs, s_vs, s_ls, s_fs}, exp_small(0, 1'b0));
    repeat (len) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c25 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_div(3500);

    // Stall with the pixel clock stuck high, then resume.
    @(negedge clk);
    c25 = 1'b1;
    div_phase = 0;
    hold_level(100);
    run_div(2000);

    pulse_reset(2);
    run_div(800);

    for (int i = 0; i < 80; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        @(negedge clk);
        c25 = 1'($urandom_range(0, 1));
        hold_level(int'($urandom_range(1, 60)));
      end else if (op == 1) begin
        run_div(int'($urandom_range(1, 400)));
        pulse_reset(int'($urandom_range(1, 3)));
      end else begin
        run_div(int'($urandom_range(50, 600)));
      end
    end

    run_div(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
